// File: rtl/bus_arb_pkg.sv
// rtl/bus_arb_pkg.sv - shared types and helpers for the multi-master bus arbiter
package bus_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  localparam int ARB_FIXED = 0;
  localparam int ARB_RR    = 1;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/bus_arb_picker.sv
// rtl/bus_arb_picker.sv - combinational winner selection, fixed priority or round-robin
module bus_arb_picker
  import bus_arb_pkg::*;
#(
  parameter int N     = 2,
  parameter int IDX_W = idx_width(N)
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] rr_ptr_i,
  input  logic             mode_i,
  output logic [IDX_W-1:0] win_idx_o,
  output logic             any_req_o
);

  logic found;

  always_comb begin
    int j;
    win_idx_o = '0;
    found     = 1'b0;
    any_req_o = |req_i;
    j         = 0;
    if (mode_i) begin
      // scan upward from the pointer, wrapping at N
      for (int k = 0; k < N; k++) begin
        j = int'(rr_ptr_i) + k;
        if (j >= N) j = j - N;
        if (!found && req_i[j]) begin
          win_idx_o = IDX_W'(j);
          found     = 1'b1;
        end
      end
    end else begin
      for (int i = N - 1; i >= 0; i--) begin
        if (req_i[i]) win_idx_o = IDX_W'(i);
      end
    end
  end

endmodule

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - N-master CPU bus arbiter with lock bursts and slave timeout
module bus_arbiter
  import bus_arb_pkg::*;
#(
  parameter int NUM_MASTERS    = 2,
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 32,
  parameter int ARB_MODE       = 0,
  parameter int TIMEOUT_CYCLES = 0,
  parameter int IDX_W          = idx_width(NUM_MASTERS)
) (
  input  logic                              clk,
  input  logic                              reset,
  input  logic [NUM_MASTERS-1:0]            mBusValid,
  input  logic [NUM_MASTERS-1:0]            mBusInstr,
  input  logic [NUM_MASTERS-1:0]            mBusWriteEnable,
  input  logic [NUM_MASTERS-1:0]            mBusLock,
  input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mAddress,
  input  logic [NUM_MASTERS*DATA_WIDTH-1:0] mDataOut,
  output logic [DATA_WIDTH-1:0]             mDataIn,
  output logic [NUM_MASTERS-1:0]            mBusReady,
  output logic [NUM_MASTERS-1:0]            mBusError,
  output logic                              sBusValid,
  output logic                              sBusInstr,
  output logic                              sBusWriteEnable,
  output logic [ADDR_WIDTH-1:0]             sAddress,
  output logic [DATA_WIDTH-1:0]             sDataOut,
  input  logic [DATA_WIDTH-1:0]             sDataIn,
  input  logic                              sBusReady,
  output logic                              grantValid,
  output logic [IDX_W-1:0]                  grantIdx
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_MASTERS - 1);

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] rr_q, rr_d;
  logic [TMO_W-1:0] tmo_q, tmo_d;

  logic [IDX_W-1:0] win_idx;
  logic [IDX_W-1:0] rr_next;
  logic             any_req;
  logic             g_valid, g_instr, g_we, g_lock;
  logic             busy, done, tmo_hit;

  bus_arb_picker #(
    .N     (NUM_MASTERS),
    .IDX_W (IDX_W)
  ) u_picker (
    .req_i     (mBusValid),
    .rr_ptr_i  (rr_q),
    .mode_i    (ARB_MODE == ARB_RR),
    .win_idx_o (win_idx),
    .any_req_o (any_req)
  );

  always_comb begin
    g_valid  = 1'b0;
    g_instr  = 1'b0;
    g_we     = 1'b0;
    g_lock   = 1'b0;
    sAddress = '0;
    sDataOut = '0;
    for (int i = 0; i < NUM_MASTERS; i++) begin
      if (grant_q == IDX_W'(i)) begin
        g_valid  = mBusValid[i];
        g_instr  = mBusInstr[i];
        g_we     = mBusWriteEnable[i];
        g_lock   = mBusLock[i];
        sAddress = mAddress[i*ADDR_WIDTH +: ADDR_WIDTH];
        sDataOut = mDataOut[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  assign busy    = (state_q == BUSY);
  assign done    = busy && g_valid && sBusReady;
  // a ready arriving in the final timeout cycle still counts as a normal completion
  assign tmo_hit = (TIMEOUT_CYCLES > 0) && busy && g_valid && !sBusReady && (tmo_q == TMO_LAST);
  assign rr_next = (grant_q == LAST_IDX) ? '0 : grant_q + 1'b1;

  assign sBusValid       = busy && g_valid && !tmo_hit;
  assign sBusInstr       = g_instr;
  assign sBusWriteEnable = g_we;
  assign mDataIn         = sDataIn;
  assign grantValid      = busy;
  assign grantIdx        = grant_q;

  always_comb begin
    for (int i = 0; i < NUM_MASTERS; i++) begin
      mBusReady[i] = (grant_q == IDX_W'(i)) && (done || tmo_hit);
      mBusError[i] = (grant_q == IDX_W'(i)) && tmo_hit;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    rr_d    = rr_q;
    tmo_d   = tmo_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = BUSY;
          grant_d = win_idx;
          tmo_d   = '0;
        end
      end
      BUSY: begin
        if (done) begin
          rr_d  = rr_next;
          tmo_d = '0;
          if (!g_lock) state_d = IDLE;
        end else if (tmo_hit) begin
          rr_d    = rr_next;
          tmo_d   = '0;
          state_d = IDLE;
        end else if (!g_valid) begin
          state_d = IDLE;
        end else if (TIMEOUT_CYCLES > 0) begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      rr_q    <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      rr_q    <= rr_d;
      tmo_q   <= tmo_d;
    end
  end

endmodule
